// File: rtl/sram_responder.sv
// Memory-side responder for the CPU's asynchronous SRAM-style bus.
// Fixed read/write latency, per-byte-lane tristate drive, Ready/Err status pulses.
module sram_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        UB,
  input  logic        LB,
  input  logic        OE,
  input  logic        WE,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        Ready,
  output logic        Err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BUS_AW = 20;
  localparam int unsigned DEPTH  = 1 << ADDR_BITS;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] RD_RELOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_RELOAD = CNT_W'(WRITE_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_WAIT,
    WR_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BUS_AW-1:0]      addr_q;
  logic                   oor_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   wub_q, wlb_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   ready_q, err_q;

  logic [DATA_W-1:0]      mem [DEPTH];

  logic                   latch_rd, latch_wr, load_rd, commit;

  // Request decode: WE low wins over OE
  logic rd_req_c, wr_req_c, addr_same_c, addr_oor_c;
  assign rd_req_c    = ~CE & WE & ~OE;
  assign wr_req_c    = ~CE & ~WE;
  assign addr_same_c = (ADDR == addr_q);
  assign addr_oor_c  = |ADDR[BUS_AW-1:ADDR_BITS];

  // Read source: the live address when a read is (re)started this cycle
  logic [BUS_AW-1:0] rd_addr_c;
  logic              rd_oor_c;
  assign rd_addr_c = latch_rd ? ADDR : addr_q;
  assign rd_oor_c  = |rd_addr_c[BUS_AW-1:ADDR_BITS];

  // Next-state, counter and strobe decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_rd = 1'b0;
    latch_wr = 1'b0;
    load_rd  = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_req_c) begin
          latch_wr = 1'b1;
          cnt_d    = WR_RELOAD;
          state_d  = WR_WAIT;
        end else if (rd_req_c) begin
          latch_rd = 1'b1;
        end
      end
      RD_WAIT: begin
        if (!rd_req_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!addr_same_c) begin
          latch_rd = 1'b1;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = RD_DRIVE;
          cnt_d   = '0;
          load_rd = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RD_DRIVE: begin
        if (!rd_req_c) begin
          state_d = IDLE;
        end else if (!addr_same_c) begin
          latch_rd = 1'b1;
        end
      end
      WR_WAIT: begin
        // Already accepted: commits even if the request is withdrawn
        if (cnt_q <= CNT_ONE) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      WR_HOLD: begin
        if (WE | CE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Common read start / restart on address change
    if (latch_rd) begin
      if (READ_LAT == 1) begin
        state_d = RD_DRIVE;
        cnt_d   = '0;
        load_rd = 1'b1;
      end else begin
        state_d = RD_WAIT;
        cnt_d   = RD_RELOAD;
      end
    end
  end

  // Control and capture registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      wub_q   <= 1'b0;
      wlb_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= load_rd | commit;
      err_q   <= (load_rd & rd_oor_c) | (commit & oor_q);
      if (latch_rd | latch_wr) begin
        addr_q <= ADDR;
        oor_q  <= addr_oor_c;
      end
      if (latch_wr) begin
        wdata_q <= Data;
        wub_q   <= ~UB;
        wlb_q   <= ~LB;
      end
      if (load_rd) begin
        rdata_q <= rd_oor_c ? '0 : mem[rd_addr_c[ADDR_BITS-1:0]];
      end
    end
  end

  // Storage array; deliberately not reset so contents survive Reset
  always_ff @(posedge Clk) begin
    if (commit && !oor_q) begin
      if (wub_q) mem[addr_q[ADDR_BITS-1:0]][15:8] <= wdata_q[15:8];
      if (wlb_q) mem[addr_q[ADDR_BITS-1:0]][7:0]  <= wdata_q[7:0];
    end
  end

  // Lane drive follows live strobes so withdrawal or address change releases at once
  logic drive_c, drive_hi_c, drive_lo_c;
  assign drive_c    = (state_q == RD_DRIVE) & rd_req_c & addr_same_c;
  assign drive_hi_c = drive_c & ~UB;
  assign drive_lo_c = drive_c & ~LB;

  assign Data[15:8] = drive_hi_c ? rdata_q[15:8] : 8'hzz;
  assign Data[7:0]  = drive_lo_c ? rdata_q[7:0]  : 8'hzz;

  assign Ready = ready_q;
  assign Err   = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Randomized bench for sram_responder against an array-based memory model.
// The bus net pulls up, so undriven lanes read back as 8'hFF.
module tb_sram_responder;

  localparam int unsigned ADDR_BITS = 10;
  localparam int unsigned READ_LAT  = 2;
  localparam int unsigned WRITE_LAT = 1;
  localparam int unsigned DEPTH     = 1 << ADDR_BITS;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce    = 1'b1;
  logic        ub    = 1'b1;
  logic        lb    = 1'b1;
  logic        oe    = 1'b1;
  logic        we    = 1'b1;
  logic [19:0] addr  = '0;
  logic        tb_drive = 1'b0;
  logic [15:0] tb_data  = '0;
  tri1  [15:0] data_bus;
  logic        ready, err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem_model [DEPTH];

  assign data_bus = tb_drive ? tb_data : 16'hzzzz;

  sram_responder #(
    .ADDR_BITS(ADDR_BITS),
    .READ_LAT (READ_LAT),
    .WRITE_LAT(WRITE_LAT)
  ) dut (
    .Clk  (clk),
    .Reset(rst_n),
    .CE   (ce),
    .UB   (ub),
    .LB   (lb),
    .OE   (oe),
    .WE   (we),
    .ADDR (addr),
    .Data (data_bus),
    .Ready(ready),
    .Err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit is_oor(input logic [19:0] a);
    return (a >> ADDR_BITS) != 20'd0;
  endfunction

  // Bus value seen by the CPU: disabled lanes float (pulled up)
  function automatic logic [15:0] read_expect(input logic [19:0] a, input logic u, input logic l);
    logic [15:0] v;
    v = is_oor(a) ? 16'h0000 : mem_model[a[ADDR_BITS-1:0]];
    return {u ? 8'hFF : v[15:8], l ? 8'hFF : v[7:0]};
  endfunction

  function automatic void model_write(input logic [19:0] a, input logic [15:0] d,
                                      input logic u, input logic l);
    if (!is_oor(a)) begin
      if (!u) mem_model[a[ADDR_BITS-1:0]][15:8] = d[15:8];
      if (!l) mem_model[a[ADDR_BITS-1:0]][7:0]  = d[7:0];
    end
  endfunction

  function automatic logic [19:0] pool_addr(input int p);
    return (p < 24) ? 20'(p) : 20'(DEPTH - 8 + (p - 24));
  endfunction

  // Counts edges from the sampling edge until Ready; 0 means it never came
  task automatic wait_ready(input int exp_lat, input bit is_write, input string tag);
    int lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (is_write) begin
        tb_drive = 1'b0;
        ub = 1'($urandom);
        lb = 1'($urandom);
      end
      @(negedge clk);
      if (is_write) check({tag, "_bus"}, 32'(data_bus), 32'hFFFF);
      if (ready) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_read(input logic [19:0] a, input logic u, input logic l, input string tag);
    logic [15:0] exp;
    exp = read_expect(a, u, l);
    @(posedge clk); #1;
    ce = 1'b0; oe = 1'b0; we = 1'b1; addr = a; ub = u; lb = l;
    wait_ready(READ_LAT, 1'b0, tag);
    check({tag, "_data"}, 32'(data_bus), 32'(exp));
    check({tag, "_err"}, 32'(err), 32'(is_oor(a)));
    @(posedge clk); @(negedge clk);
    check({tag, "_pulse"}, 32'(ready), 32'h0);
    check({tag, "_hold"}, 32'(data_bus), 32'(exp));
    ce = 1'b1; oe = 1'b1; #1;
    check({tag, "_rel"}, 32'(data_bus), 32'hFFFF);
  endtask

  task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic u,
                          input logic l, input logic o, input string tag);
    int hold;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0; oe = o; addr = a; ub = u; lb = l; tb_data = d; tb_drive = 1'b1;
    wait_ready(WRITE_LAT + 1, 1'b1, tag);
    check({tag, "_err"}, 32'(err), 32'(is_oor(a)));
    model_write(a, d, u, l);
    hold = $urandom_range(0, 2);
    for (int i = 0; i <= hold; i++) begin
      @(posedge clk); @(negedge clk);
      check({tag, "_once"}, 32'(ready), 32'h0);
    end
    ce = 1'b1; we = 1'b1; oe = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_bus", 32'(data_bus), 32'hFFFF);
    rst_n = 1'b1;

    // Known contents for every address the bench will read
    for (int p = 0; p < 32; p++)
      do_write(pool_addr(p), 16'($urandom), 1'b0, 1'b0, 1'b1, "init");

    // Basic write then read at default latency
    do_write(20'h00012, 16'hBEEF, 1'b0, 1'b0, 1'b1, "t2_wr");
    do_read(20'h00012, 1'b0, 1'b0, "t2_rd");

    // Reset asserted in the first drive cycle releases everything at once
    @(posedge clk); #1;
    ce = 1'b0; oe = 1'b0; we = 1'b1; addr = 20'h00012; ub = 1'b0; lb = 1'b0;
    wait_ready(READ_LAT, 1'b0, "t1_rd");
    #2 rst_n = 1'b0;
    #1;
    check("t1_ready", 32'(ready), 32'h0);
    check("t1_err", 32'(err), 32'h0);
    check("t1_bus", 32'(data_bus), 32'hFFFF);
    ce = 1'b1; oe = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Reset during a pending write discards it
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0; addr = 20'h00012; ub = 1'b0; lb = 1'b0;
    tb_data = 16'h5555; tb_drive = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; ce = 1'b1; we = 1'b1; tb_drive = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_wr_ready", 32'(ready), 32'h0);
    rst_n = 1'b1;
    do_read(20'h00012, 1'b0, 1'b0, "t1_nocommit");

    // Byte lanes
    do_write(20'h00005, 16'h1234, 1'b0, 1'b0, 1'b1, "t3_wr");
    do_write(20'h00005, 16'hFFAA, 1'b1, 1'b0, 1'b1, "t3_wrlo");
    do_read(20'h00005, 1'b0, 1'b0, "t3_full");
    do_read(20'h00005, 1'b0, 1'b1, "t3_hi");

    // Address change while driving restarts the latency
    @(posedge clk); #1;
    ce = 1'b0; oe = 1'b0; we = 1'b1; addr = 20'h00005; ub = 1'b0; lb = 1'b0;
    wait_ready(READ_LAT, 1'b0, "t4_first");
    check("t4_first_data", 32'(data_bus), 32'h12AA);
    @(posedge clk); #1;
    addr = 20'h00012; #1;
    check("t4_release", 32'(data_bus), 32'hFFFF);
    wait_ready(READ_LAT, 1'b0, "t4_second");
    check("t4_data", 32'(data_bus), 32'hBEEF);
    @(posedge clk); @(negedge clk);
    check("t4_pulse", 32'(ready), 32'h0);
    ce = 1'b1; oe = 1'b1;

    // Out of range
    do_write(20'h00000, 16'h1357, 1'b0, 1'b0, 1'b1, "t5_base");
    do_write(20'h00400, 16'hAAAA, 1'b0, 1'b0, 1'b1, "t5_wr");
    do_read(20'h00000, 1'b0, 1'b0, "t5_base_rd");
    do_read(20'h00400, 1'b0, 1'b0, "t5_rd");

    // WE beats OE; the block must not drive during the write
    do_write(20'h00007, 16'h0F0F, 1'b0, 1'b0, 1'b0, "t6_prec");
    do_read(20'h00007, 1'b0, 1'b0, "t6_prec_rd");

    // Read withdrawn during the latency wait
    @(posedge clk); #1;
    ce = 1'b0; oe = 1'b0; we = 1'b1; addr = 20'h00005; ub = 1'b0; lb = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t6_abort_early", 32'(ready), 32'h0);
    oe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("t6_abort_ready", 32'(ready), 32'h0);
      check("t6_abort_bus", 32'(data_bus), 32'hFFFF);
    end
    ce = 1'b1;
    do_write(20'h00009, 16'hC0DE, 1'b0, 1'b0, 1'b1, "t6_after");

    // Random mix of reads and writes
    for (int n = 0; n < 80; n++) begin
      logic [19:0] a;
      if ($urandom_range(0, 7) == 0)
        a = {10'($urandom_range(1, 1023)), 10'($urandom)};
      else
        a = pool_addr($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0)
        do_write(a, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rnd_wr");
      else
        do_read(a, 1'($urandom), 1'($urandom), "rnd_rd");
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
